// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides, an internal accumulator
// operand, carry/overflow/zero/illegal-op flags and optional signed saturation.
module alu_pipe #(
    parameter int WIDTH  = 8,
    parameter bit SAT_EN = 1'b0,
    parameter int SH_W   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             acc_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             c,
    output logic             v,
    output logic             z,
    output logic             err
);
    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4,  OP_NOT = 4'd5,  OP_SHL = 4'd6,  OP_SHR = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8,  OP_ROL = 4'd9,  OP_INC = 4'd10, OP_DEC = 4'd11;
    localparam logic [3:0] OP_PASS = 4'd12, OP_CLRACC = 4'd13;
    localparam int MSB = WIDTH - 1;

    // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
    // the sender holds its payload stable while valid=1 and ready=0.

    logic [WIDTH-1:0]   acc_q;
    logic               s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]   s1_res_q;
    logic               s1_c_q, s1_v_q, s1_z_q, s1_err_q;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_q;
    logic               c_q, v_q, z_q, err_q;

    logic               adv, accept;
    logic [WIDTH-1:0]   opa, arith_x, arith_y, res_d;
    logic               arith_sub, ovf, c_d, v_d, z_d, err_d;
    logic [WIDTH:0]     sum, shl_t, shr_t, sra_t;
    logic [2*WIDTH-1:0] rol_t;
    logic [SH_W-1:0]    sh;

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || adv;
    assign accept    = in_valid && in_ready;

    assign opa       = acc_sel ? acc_q : a;
    assign sh        = b[SH_W-1:0];
    assign arith_sub = (op == OP_SUB) || (op == OP_DEC);
    assign arith_x   = ((op == OP_ADD) || (op == OP_SUB)) ? b : WIDTH'(1);
    // Subtraction is A + ~x + 1, so carry-out doubles as "no borrow".
    assign arith_y   = arith_sub ? ~arith_x : arith_x;
    assign sum       = {1'b0, opa} + {1'b0, arith_y} + {{WIDTH{1'b0}}, arith_sub};
    assign ovf       = (opa[MSB] == arith_y[MSB]) && (sum[MSB] != opa[MSB]);

    // Padding bits catch the last bit shifted out; they stay 0 for a zero shift.
    assign shl_t = {1'b0, opa} << sh;
    assign shr_t = {opa, 1'b0} >> sh;
    assign sra_t = $signed({opa, 1'b0}) >>> sh;
    assign rol_t = {opa, opa} << sh;

    always_comb begin
        res_d = '0;
        c_d   = 1'b0;
        v_d   = 1'b0;
        err_d = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
                res_d = sum[WIDTH-1:0];
                c_d   = sum[WIDTH];
                v_d   = ovf;
                // On overflow the true result has the sign of A.
                if (SAT_EN && ovf) begin
                    res_d = opa[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end
            OP_AND:    res_d = opa & b;
            OP_OR:     res_d = opa | b;
            OP_XOR:    res_d = opa ^ b;
            OP_NOT:    res_d = ~opa;
            OP_SHL: begin
                res_d = shl_t[WIDTH-1:0];
                c_d   = shl_t[WIDTH];
            end
            OP_SHR: begin
                res_d = shr_t[WIDTH:1];
                c_d   = shr_t[0];
            end
            OP_SRA: begin
                res_d = sra_t[WIDTH:1];
                c_d   = sra_t[0];
            end
            OP_ROL: begin
                res_d = rol_t[2*WIDTH-1:WIDTH];
                c_d   = (sh != '0) && rol_t[WIDTH];
            end
            OP_PASS:   res_d = b;
            OP_CLRACC: res_d = '0;
            default:   err_d = 1'b1;
        endcase
    end

    assign z_d = (res_d == '0);

    // Stage 1 refills on accept; otherwise it empties only when stage 2 can take it.
    assign s1_valid_d  = accept || (s1_valid_q && !adv);
    assign out_valid_d = adv ? s1_valid_q : out_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_res_q    <= '0;
            s1_c_q      <= 1'b0;
            s1_v_q      <= 1'b0;
            s1_z_q      <= 1'b0;
            s1_err_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            z_q         <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            if (accept && !err_d) begin
                acc_q <= res_d;
            end
            if (accept) begin
                s1_res_q <= res_d;
                s1_c_q   <= c_d;
                s1_v_q   <= v_d;
                s1_z_q   <= z_d;
                s1_err_q <= err_d;
            end
            if (adv && s1_valid_q) begin
                out_q <= s1_res_q;
                c_q   <= s1_c_q;
                v_q   <= s1_v_q;
                z_q   <= s1_z_q;
                err_q <= s1_err_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign c         = c_q;
    assign v         = v_q;
    assign z         = z_q;
    assign err       = err_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: a plain and a saturating instance share stimulus; each is
// scored against an integer reference model with per-instance expected queues.
module tb_alu_pipe;
  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] op;
  logic       acc_sel;
  logic       out_ready;

  logic       in_ready0, out_valid0, c0, v0, z0, err0;
  logic [7:0] out0;
  logic       in_ready1, out_valid1, c1, v1, z1, err1;
  logic [7:0] out1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_m[2];
  logic [11:0] exp_q0[$];
  logic [11:0] exp_q1[$];
  int cyc_q0[$];
  int cyc_q1[$];

  alu_pipe #(.WIDTH(8), .SAT_EN(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .op(op), .acc_sel(acc_sel),
    .out_valid(out_valid0), .out_ready(out_ready), .out(out0),
    .c(c0), .v(v0), .z(z0), .err(err0)
  );

  alu_pipe #(.WIDTH(8), .SAT_EN(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .op(op), .acc_sel(acc_sel),
    .out_valid(out_valid1), .out_ready(out_ready), .out(out1),
    .c(c1), .v(v1), .z(z1), .err(err1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sgn(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  // Reference: integer arithmetic straight from the opcode table.
  function automatic logic [11:0] model(input int idx, input int a_i, input int b_i,
                                        input int opc, input int sel);
    int av, s, r, cc, vv, ee, x, t, sr;
    logic [7:0] rb;
    logic sub;
    av = sel ? acc_m[idx] : a_i;
    s  = b_i & 7;
    r = 0; cc = 0; vv = 0; ee = 0;
    case (opc)
      0, 1, 10, 11: begin
        x   = (opc <= 1) ? b_i : 1;
        sub = (opc == 1) || (opc == 11);
        sr  = sub ? sgn(av) - sgn(x) : sgn(av) + sgn(x);
        t   = sub ? av + (x ^ 255) + 1 : av + x;
        cc  = (t >> 8) & 1;
        r   = t & 255;
        vv  = (sr > 127 || sr < -128) ? 1 : 0;
        if (idx == 1 && vv == 1) r = (sr > 0) ? 127 : 128;
      end
      2:  r = av & b_i;
      3:  r = av | b_i;
      4:  r = av ^ b_i;
      5:  r = (~av) & 255;
      6:  begin r = (av << s) & 255;              cc = (s != 0) ? (av >> (8 - s)) & 1 : 0; end
      7:  begin r = av >> s;                      cc = (s != 0) ? (av >> (s - 1)) & 1 : 0; end
      8:  begin r = (sgn(av) >>> s) & 255;        cc = (s != 0) ? (av >> (s - 1)) & 1 : 0; end
      9:  begin r = ((av << s) | (av >> (8 - s))) & 255; cc = (s != 0) ? (av >> (8 - s)) & 1 : 0; end
      12: r = b_i;
      13: r = 0;
      default: ee = 1;
    endcase
    if (ee == 0) acc_m[idx] = r;
    rb = r[7:0];
    return {rb, cc[0], vv[0], (r == 0), ee[0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: handshake, latency and payload of one instance
  task automatic chk(input int idx, input logic irdy, input logic ov, input logic [11:0] obs);
    int sz, hc;
    logic [11:0] he;
    sz = (idx == 0) ? exp_q0.size() : exp_q1.size();
    he = '0;
    hc = 0;
    if (sz > 0) begin
      he = (idx == 0) ? exp_q0[0] : exp_q1[0];
      hc = (idx == 0) ? cyc_q0[0] : cyc_q1[0];
    end
    check($sformatf("in_ready[%0d]", idx), 32'(irdy), 32'((sz < 2) || out_ready));
    check($sformatf("out_valid[%0d]", idx), 32'(ov), 32'((sz > 0) && (hc + 2 <= cyc)));
    if (ov && sz > 0) begin
      check($sformatf("result[%0d] {out,c,v,z,err}", idx), 32'(obs), 32'(he));
      if (out_ready) begin
        if (idx == 0) begin void'(exp_q0.pop_front()); void'(cyc_q0.pop_front()); end
        else          begin void'(exp_q1.pop_front()); void'(cyc_q1.pop_front()); end
      end
    end
  endtask

  // driver: one clock cycle of stimulus
  task automatic step(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                      input logic [3:0] iop, input logic isel, input logic ordy,
                      output logic got);
    @(negedge clk);
    in_valid = iv; a = ia; b = ib; op = iop; acc_sel = isel; out_ready = ordy;
    #1;
    chk(0, in_ready0, out_valid0, {out0, c0, v0, z0, err0});
    chk(1, in_ready1, out_valid1, {out1, c1, v1, z1, err1});
    got = iv && in_ready0;
    if (iv && in_ready0) begin
      exp_q0.push_back(model(0, int'(ia), int'(ib), int'(iop), int'(isel)));
      cyc_q0.push_back(cyc);
    end
    if (iv && in_ready1) begin
      exp_q1.push_back(model(1, int'(ia), int'(ib), int'(iop), int'(isel)));
      cyc_q1.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic send(input logic [7:0] ia, input logic [7:0] ib, input logic [3:0] iop,
                      input logic isel);
    logic got;
    int n;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      step(1'b1, ia, ib, iop, isel, 1'b1, got);
      n++;
    end
    check("send_accept_timeout", 32'(got), 32'(1));
  endtask

  task automatic idle(input int n);
    logic got;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, got);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid0"}, 32'(out_valid0), 32'(0));
    check({tag, "_out_valid1"}, 32'(out_valid1), 32'(0));
    check({tag, "_outs0"}, 32'({out0, c0, v0, z0, err0}), 32'(0));
    check({tag, "_outs1"}, 32'({out1, c1, v1, z1, err1}), 32'(0));
  endtask

  initial begin
    logic got;
    logic [7:0] bp_a[5];
    logic [7:0] bp_b[5];
    int bp_idx;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; acc_sel = 1'b0; out_ready = 1'b1;
    acc_m[0] = 0; acc_m[1] = 0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);

    // directed arithmetic / flag cases
    send(8'h7F, 8'h01, 4'd0, 1'b0);
    idle(1);
    send(8'h05, 8'h05, 4'd1, 1'b0);
    send(8'h00, 8'h01, 4'd1, 1'b0);
    send(8'h80, 8'h01, 4'd1, 1'b0);
    // accumulate chain back-to-back: 0, 3, 7, 14
    send(8'h00, 8'h00, 4'd13, 1'b0);
    send(8'h00, 8'h03, 4'd0, 1'b1);
    send(8'h00, 8'h04, 4'd0, 1'b1);
    send(8'h00, 8'h01, 4'd6, 1'b1);
    send(8'h81, 8'h01, 4'd9, 1'b0);
    // illegal op must leave acc untouched
    send(8'h00, 8'h00, 4'd14, 1'b0);
    send(8'h00, 8'h00, 4'd0, 1'b1);
    send(8'hA5, 8'h03, 4'd8, 1'b0);
    send(8'h3C, 8'h00, 4'd7, 1'b0);
    idle(4);

    // backpressure: five ops while the consumer stalls for four cycles
    for (int i = 0; i < 5; i++) begin
      bp_a[i] = 8'(i * 37 + 11);
      bp_b[i] = 8'(i * 5 + 2);
    end
    bp_idx = 0;
    for (int t = 0; t < 20; t++) begin
      if (bp_idx < 5) begin
        step(1'b1, bp_a[bp_idx], bp_b[bp_idx], 4'(bp_idx), 1'b0, (t >= 4), got);
        if (got) bp_idx++;
      end else begin
        step(1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, got);
      end
    end
    check("backpressure_all_accepted", 32'(bp_idx), 32'(5));

    // random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), got);
    end
    idle(4);

    // reset with two ops in flight
    step(1'b1, 8'h11, 8'h22, 4'd0, 1'b0, 1'b0, got);
    step(1'b1, 8'h33, 8'h44, 4'd3, 1'b0, 1'b0, got);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    exp_q0.delete(); exp_q1.delete(); cyc_q0.delete(); cyc_q1.delete();
    acc_m[0] = 0; acc_m[1] = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    idle(4);
    send(8'h55, 8'h00, 4'd0, 1'b1);

    // drain with a bounded budget
    for (int i = 0; i < 50 && (exp_q0.size() + exp_q1.size()) > 0; i++) idle(1);
    check("drain_left0", 32'(exp_q0.size()), 32'(0));
    check("drain_left1", 32'(exp_q1.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, 2-stage pipelined successor to the single-cycle 8-bit ALU.
- Adds width/shift generalisation, valid/ready handshakes on input and output, an internal accumulator operand, overflow/zero/illegal-op flags and optional signed saturation.
- Sits in the datapath test harness as the arithmetic unit, fed by a stimulus driver and drained by a scoreboard/monitor.

Parameters:
- WIDTH, 8, operand/result width (>=4, power of 2).
- SAT_EN, 0, 1 = ADD/SUB/INC/DEC clamp to signed max/min on overflow.
- SH_W, $clog2(WIDTH), shift-amount bits taken from b[SH_W-1:0].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block accepts operation this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  4  opcode.
- acc_sel  in  1  1 = use accumulator in place of a.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out  out  WIDTH  result.
- c  out  1  carry-out (ADD/INC), not-borrow (SUB/DEC), last bit shifted out (shifts); 0 otherwise.
- v  out  1  signed overflow (ADD/SUB/INC/DEC only).
- z  out  1  out == 0.
- err  out  1  illegal opcode.

Behaviour:
- Reset (async, rst=1):
  - s1_valid=0, out_valid=0, out=0, c=v=z=err=0, acc=0.
  - in_ready=1 combinationally once out of reset.
- Opcodes, with A = acc_sel ? acc : a:
  - 0 ADD A+b; 1 SUB A-b; 2 AND; 3 OR; 4 XOR; 5 NOT A.
  - 6 SHL A<<s; 7 SHR logical; 8 SRA; 9 ROL (s = b[SH_W-1:0]).
  - 10 INC A+1; 11 DEC A-1; 12 PASS b; 13 CLRACC (out=0, acc=0).
  - 14/15 illegal: out=0, c=v=0, err=1, acc unchanged.
- Arithmetic and flags:
  - Arithmetic is computed in WIDTH+1 bits; c = bit WIDTH. SUB/DEC use A+~x+1, so c=1 means no borrow.
  - Shift by 0: out=A, c=0.
  - SAT_EN=1 and v=1: out = 0111..1 if true result is positive, 1000..0 if negative; v still reported 1.
  - z is computed on the final (possibly saturated) out.
- Pipeline:
  - Stage 1 computes and registers result/flags on accept.
  - Stage 2 is the output register.
  - adv = !out_valid || out_ready.
  - in_ready = !s1_valid || adv.
  - Accept = in_valid && in_ready.
  - Latency from accept to out_valid is 2 cycles; throughput is 1 op/cycle with out_ready=1.
- Accumulator:
  - acc is written with the result in the same edge the op enters stage 1 (all legal ops; CLRACC writes 0).
  - Back-to-back acc_sel ops therefore see the immediately preceding op's result; no hazard stall.
- Backpressure:
  - out_valid && !out_ready holds out/c/v/z/err stable.
  - Stage 1 holds; once stage 1 is also full, in_ready=0.
  - No operation is dropped or duplicated.
- in_valid=0 with adv=1: stage 1 empties and out_valid falls after the bubble propagates.
- Reset mid-operation: all in-flight ops are discarded, acc cleared, outputs zeroed in the same cycle rst asserts.
- Output values are don't-care-stable only while out_valid=1; while out_valid=0 they hold their last value.

Test Plan:
- Reset release, then ADD a=8'h7F b=8'h01 -> 2 cycles later out_valid=1, out=8'h80, c=0, v=1, z=0.
- SUB a=8'h05 b=8'h05 -> out=8'h00, c=1, v=0, z=1.
- SUB a=8'h00 b=8'h01 -> out=8'hFF, c=0.
- With SAT_EN=1, ADD 8'h7F+8'h01 -> out=8'h7F, v=1.
- With SAT_EN=1, SUB 8'h80-8'h01 -> out=8'h80, v=1.
- Accumulate chain, back-to-back: CLRACC; ADD acc_sel=1 b=3; ADD acc_sel=1 b=4; SHL acc_sel=1 b=1 -> results 0, 3, 7, 14 on consecutive cycles.
- Backpressure: stream 5 ops with out_ready=0 -> in_ready=0 after 2 accepts; release out_ready -> all 5 results emerge in order, none lost, outputs stable while stalled.
- op=4'hE -> err=1, out=0, acc unchanged (next ADD acc_sel=1 b=0 returns prior acc).
- ROL a=8'h81 b=1 -> out=8'h03, c=1.
- Reset asserted with 2 ops in flight -> out_valid=0 immediately, acc=0, and no stale result appears after release.
